// File: rtl/axi_ram_arb_pkg.sv
// axi_ram_arb_pkg: shared types and helpers for the RAM read-port arbiter.
//   state_t : arbiter FSM state (IDLE searches round-robin, LOCKED holds a burst)
//   idx_w   : bit width needed to index n requesters (at least 1)
package axi_ram_arb_pkg;
  typedef enum logic {IDLE, LOCKED} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_ram_arb_tag_fifo.sv
// axi_ram_arb_tag_fifo: synchronous FIFO recording which port issued each RAM beat.
//   clk, rst_n : clock and async active-low reset
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   head       : oldest entry
//   full/empty : derived from a registered occupancy count
module axi_ram_arb_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd];
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  always_ff @(posedge clk) if (do_push) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/axi_ram_rd_arbiter.sv
// axi_ram_rd_arbiter: shares one RAM read port between PORTS requesters.
//   s_cmd_*  : per-port command streams (fields packed port i at [i*W +: W])
//   s_resp_* : response stream, id/data/last broadcast, valid one-hot per port
//   m_cmd_*  : muxed command stream to the RAM
//   m_resp_* : in-order response stream from the RAM
// Round-robin grant, locked for a whole burst; a tag FIFO routes each
// response beat back to the port that issued the matching command beat.
module axi_ram_rd_arbiter
  import axi_ram_arb_pkg::*;
#(
  parameter int PORTS       = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int ID_WIDTH    = 8,
  parameter int OUTSTANDING = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*ID_WIDTH-1:0]   s_cmd_id,
  input  logic [PORTS*ADDR_WIDTH-1:0] s_cmd_addr,
  input  logic [PORTS-1:0]            s_cmd_en,
  input  logic [PORTS-1:0]            s_cmd_last,
  output logic [PORTS-1:0]            s_cmd_ready,
  output logic [PORTS*ID_WIDTH-1:0]   s_resp_id,
  output logic [PORTS*DATA_WIDTH-1:0] s_resp_data,
  output logic [PORTS-1:0]            s_resp_last,
  output logic [PORTS-1:0]            s_resp_valid,
  input  logic [PORTS-1:0]            s_resp_ready,
  output logic [ID_WIDTH-1:0]         m_cmd_id,
  output logic [ADDR_WIDTH-1:0]       m_cmd_addr,
  output logic                        m_cmd_en,
  output logic                        m_cmd_last,
  input  logic                        m_cmd_ready,
  input  logic [ID_WIDTH-1:0]         m_resp_id,
  input  logic [DATA_WIDTH-1:0]       m_resp_data,
  input  logic                        m_resp_last,
  input  logic                        m_resp_valid,
  output logic                        m_resp_ready
);
  localparam int PW = idx_w(PORTS);
  state_t state;
  logic [PW-1:0] rr_ptr, lock_port, rr_sel, sel, idx, head;
  logic found, full, empty, accept, pop;
  always_comb begin
    rr_sel = rr_ptr;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx = PW'((int'(rr_ptr) + k) % PORTS);
      if (!found && s_cmd_en[idx]) begin
        rr_sel = idx;
        found = 1'b1;
      end
    end
  end
  assign sel = (state == LOCKED) ? lock_port : rr_sel;
  assign m_cmd_id = s_cmd_id[int'(sel)*ID_WIDTH +: ID_WIDTH];
  assign m_cmd_addr = s_cmd_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_cmd_last = s_cmd_last[sel];
  // Command handshakes are gated by rst_n so nothing is offered while reset is held.
  assign m_cmd_en = rst_n & s_cmd_en[sel] & !full;
  assign s_cmd_ready = (rst_n & m_cmd_ready & !full) ? PORTS'(1) << sel : '0;
  assign accept = m_cmd_en & m_cmd_ready;
  assign s_resp_id = {PORTS{m_resp_id}};
  assign s_resp_data = {PORTS{m_resp_data}};
  assign s_resp_last = {PORTS{m_resp_last}};
  assign s_resp_valid = (m_resp_valid & !empty) ? PORTS'(1) << head : '0;
  assign m_resp_ready = !empty & s_resp_ready[head];
  assign pop = m_resp_valid & m_resp_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      lock_port <= '0;
    end else if (accept) begin
      if (m_cmd_last) begin
        state <= IDLE;
        rr_ptr <= (sel == PW'(PORTS - 1)) ? '0 : sel + 1'b1;
      end else if (state == IDLE) begin
        state <= LOCKED;
        lock_port <= sel;
      end
    end
  end
  axi_ram_arb_tag_fifo #(.WIDTH(PW), .DEPTH(OUTSTANDING)) u_tags (
    .clk(clk),
    .rst_n(rst_n),
    .push(accept),
    .din(sel),
    .pop(pop),
    .head(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_axi_ram_rd_arbiter.sv
// tb_axi_ram_rd_arbiter: directed self-checking bench for axi_ram_rd_arbiter.
module tb_axi_ram_rd_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] s_cmd_id;
  logic [31:0] s_cmd_addr;
  logic [1:0] s_cmd_en, s_cmd_last, s_cmd_ready;
  logic [15:0] s_resp_id;
  logic [63:0] s_resp_data;
  logic [1:0] s_resp_last, s_resp_valid, s_resp_ready;
  logic [7:0] m_cmd_id;
  logic [15:0] m_cmd_addr;
  logic m_cmd_en, m_cmd_last, m_cmd_ready;
  logic [7:0] m_resp_id;
  logic [31:0] m_resp_data;
  logic m_resp_last, m_resp_valid, m_resp_ready;
  int checks = 0;
  int errors = 0;

  axi_ram_rd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s_cmd_id(s_cmd_id), .s_cmd_addr(s_cmd_addr), .s_cmd_en(s_cmd_en),
    .s_cmd_last(s_cmd_last), .s_cmd_ready(s_cmd_ready),
    .s_resp_id(s_resp_id), .s_resp_data(s_resp_data), .s_resp_last(s_resp_last),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .m_cmd_id(m_cmd_id), .m_cmd_addr(m_cmd_addr), .m_cmd_en(m_cmd_en),
    .m_cmd_last(m_cmd_last), .m_cmd_ready(m_cmd_ready),
    .m_resp_id(m_resp_id), .m_resp_data(m_resp_data), .m_resp_last(m_resp_last),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    s_cmd_id = {8'hB1, 8'hA0};
    s_cmd_addr = {16'h0200, 16'h0100};
    s_cmd_en = 2'b11;
    s_cmd_last = 2'b11;
    m_cmd_ready = 1'b1;
    s_resp_ready = 2'b11;
    m_resp_id = 8'h00;
    m_resp_data = 32'h0;
    m_resp_last = 1'b1;
    m_resp_valid = 1'b1;
    tick;
    tick;
    checks++; if (m_cmd_en !== 1'b0) begin errors++; $display("FAIL in_reset m_cmd_en got %b exp 0", m_cmd_en); end
    checks++; if (s_cmd_ready !== 2'b00) begin errors++; $display("FAIL in_reset s_cmd_ready got %b exp 00", s_cmd_ready); end
    checks++; if (s_resp_valid !== 2'b00) begin errors++; $display("FAIL in_reset s_resp_valid got %b exp 00", s_resp_valid); end
    checks++; if (m_resp_ready !== 1'b0) begin errors++; $display("FAIL in_reset m_resp_ready got %b exp 0", m_resp_ready); end
    s_cmd_en = 2'b00;
    m_resp_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    #1;
    checks++; if (m_cmd_en !== 1'b0) begin errors++; $display("FAIL idle m_cmd_en got %b exp 0", m_cmd_en); end
    checks++; if (s_resp_valid !== 2'b00) begin errors++; $display("FAIL idle s_resp_valid got %b exp 00", s_resp_valid); end
    checks++; if (m_resp_ready !== 1'b0) begin errors++; $display("FAIL idle m_resp_ready got %b exp 0", m_resp_ready); end
    tick;
  endtask

  task automatic test_round_robin;
    logic [31:0] d;
    s_cmd_en = 2'b11;
    s_cmd_last = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (s_cmd_ready !== 2'(1 << (i % 2))) begin errors++; $display("FAIL rr grant %0d s_cmd_ready got %b exp %b", i, s_cmd_ready, 2'(1 << (i % 2))); end
      checks++; if (m_cmd_id !== ((i % 2) ? 8'hB1 : 8'hA0)) begin errors++; $display("FAIL rr id %0d got %h exp %h", i, m_cmd_id, (i % 2) ? 8'hB1 : 8'hA0); end
      checks++; if (m_cmd_addr !== ((i % 2) ? 16'h0200 : 16'h0100)) begin errors++; $display("FAIL rr addr %0d got %h exp %h", i, m_cmd_addr, (i % 2) ? 16'h0200 : 16'h0100); end
      tick;
    end
    s_cmd_en = 2'b00;
    for (int i = 0; i < 4; i++) begin
      d = 32'hD000_0000 + 32'(i);
      m_resp_id = (i % 2) ? 8'hB1 : 8'hA0;
      m_resp_data = d;
      m_resp_valid = 1'b1;
      #1;
      checks++; if (s_resp_valid !== 2'(1 << (i % 2))) begin errors++; $display("FAIL rr resp_valid %0d got %b exp %b", i, s_resp_valid, 2'(1 << (i % 2))); end
      checks++; if (m_resp_ready !== 1'b1) begin errors++; $display("FAIL rr m_resp_ready %0d got %b exp 1", i, m_resp_ready); end
      checks++; if (s_resp_data[(i % 2)*32 +: 32] !== d) begin errors++; $display("FAIL rr resp_data %0d got %h exp %h", i, s_resp_data[(i % 2)*32 +: 32], d); end
      tick;
    end
    #1;
    checks++; if (m_resp_ready !== 1'b0) begin errors++; $display("FAIL resp_when_empty m_resp_ready got %b exp 0", m_resp_ready); end
    checks++; if (s_resp_valid !== 2'b00) begin errors++; $display("FAIL resp_when_empty s_resp_valid got %b exp 00", s_resp_valid); end
    m_resp_valid = 1'b0;
    tick;
  endtask

  task automatic test_burst_lock;
    logic [1:0] exp_v [5];
    exp_v = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    s_cmd_en = 2'b10;
    s_cmd_last = 2'b00;
    for (int b = 0; b < 4; b++) begin
      if (b == 1) s_cmd_en = 2'b11;
      if (b == 3) s_cmd_last = 2'b11;
      #1;
      checks++; if (s_cmd_ready !== 2'b10) begin errors++; $display("FAIL burst beat %0d s_cmd_ready got %b exp 10", b, s_cmd_ready); end
      tick;
    end
    #1;
    checks++; if (s_cmd_ready !== 2'b01) begin errors++; $display("FAIL after_burst s_cmd_ready got %b exp 01", s_cmd_ready); end
    checks++; if (m_cmd_id !== 8'hA0) begin errors++; $display("FAIL after_burst m_cmd_id got %h exp a0", m_cmd_id); end
    tick;
    s_cmd_en = 2'b00;
    m_resp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (s_resp_valid !== exp_v[i]) begin errors++; $display("FAIL burst resp %0d s_resp_valid got %b exp %b", i, s_resp_valid, exp_v[i]); end
      tick;
    end
    m_resp_valid = 1'b0;
  endtask

  task automatic test_full;
    int acc = 0;
    s_cmd_en = 2'b01;
    s_cmd_last = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (m_cmd_en && m_cmd_ready) acc++;
      tick;
    end
    checks++; if (acc !== 8) begin errors++; $display("FAIL full accepts got %0d exp 8", acc); end
    #1;
    checks++; if (m_cmd_en !== 1'b0) begin errors++; $display("FAIL full m_cmd_en got %b exp 0", m_cmd_en); end
    checks++; if (s_cmd_ready !== 2'b00) begin errors++; $display("FAIL full s_cmd_ready got %b exp 00", s_cmd_ready); end
    m_resp_valid = 1'b1;
    s_resp_ready = 2'b01;
    #1;
    checks++; if (m_resp_ready !== 1'b1) begin errors++; $display("FAIL full pop m_resp_ready got %b exp 1", m_resp_ready); end
    checks++; if (m_cmd_en !== 1'b0) begin errors++; $display("FAIL full no_pop_through m_cmd_en got %b exp 0", m_cmd_en); end
    tick;
    m_resp_valid = 1'b0;
    #1;
    checks++; if (m_cmd_en !== 1'b1) begin errors++; $display("FAIL after_pop m_cmd_en got %b exp 1", m_cmd_en); end
    tick;
    #1;
    checks++; if (m_cmd_en !== 1'b0) begin errors++; $display("FAIL refull m_cmd_en got %b exp 0", m_cmd_en); end
    s_cmd_en = 2'b00;
    m_resp_valid = 1'b1;
    repeat (8) tick;
    m_resp_valid = 1'b0;
    s_resp_ready = 2'b11;
  endtask

  task automatic test_head_of_line;
    s_cmd_last = 2'b11;
    s_cmd_en = 2'b01;
    tick;
    s_cmd_en = 2'b10;
    tick;
    s_cmd_en = 2'b00;
    m_resp_valid = 1'b1;
    s_resp_ready = 2'b10;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (m_resp_ready !== 1'b0) begin errors++; $display("FAIL hol %0d m_resp_ready got %b exp 0", i, m_resp_ready); end
      checks++; if (s_resp_valid !== 2'b01) begin errors++; $display("FAIL hol %0d s_resp_valid got %b exp 01", i, s_resp_valid); end
      tick;
    end
    s_resp_ready = 2'b11;
    #1;
    checks++; if (m_resp_ready !== 1'b1) begin errors++; $display("FAIL hol release m_resp_ready got %b exp 1", m_resp_ready); end
    tick;
    #1;
    checks++; if (s_resp_valid !== 2'b10) begin errors++; $display("FAIL hol second s_resp_valid got %b exp 10", s_resp_valid); end
    tick;
    m_resp_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    s_cmd_en = 2'b01;
    s_cmd_last = 2'b01;
    tick;
    s_cmd_en = 2'b10;
    #1;
    checks++; if (s_cmd_ready !== 2'b10) begin errors++; $display("FAIL midrst grant got %b exp 10", s_cmd_ready); end
    tick;
    tick;
    s_cmd_en = 2'b11;
    m_resp_valid = 1'b1;
    s_resp_ready = 2'b11;
    #1;
    checks++; if (s_cmd_ready !== 2'b10) begin errors++; $display("FAIL midrst locked got %b exp 10", s_cmd_ready); end
    checks++; if (m_resp_ready !== 1'b1) begin errors++; $display("FAIL midrst pre m_resp_ready got %b exp 1", m_resp_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_cmd_en !== 1'b0) begin errors++; $display("FAIL midrst m_cmd_en got %b exp 0", m_cmd_en); end
    checks++; if (s_cmd_ready !== 2'b00) begin errors++; $display("FAIL midrst s_cmd_ready got %b exp 00", s_cmd_ready); end
    checks++; if (s_resp_valid !== 2'b00) begin errors++; $display("FAIL midrst s_resp_valid got %b exp 00", s_resp_valid); end
    checks++; if (m_resp_ready !== 1'b0) begin errors++; $display("FAIL midrst m_resp_ready got %b exp 0", m_resp_ready); end
    #10;
    rst_n = 1'b1;
    #1;
    checks++; if (s_cmd_ready !== 2'b01) begin errors++; $display("FAIL post_rst s_cmd_ready got %b exp 01", s_cmd_ready); end
    checks++; if (m_resp_ready !== 1'b0) begin errors++; $display("FAIL post_rst m_resp_ready got %b exp 0", m_resp_ready); end
    checks++; if (s_resp_valid !== 2'b00) begin errors++; $display("FAIL post_rst s_resp_valid got %b exp 00", s_resp_valid); end
    s_cmd_en = 2'b00;
    m_resp_valid = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_burst_lock;
    test_full;
    test_head_of_line;
    test_reset_mid_burst;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
